pulse_tx: RTL

Output-side counterpart to the input glitch filters: converts single-cycle event requests from internal logic into clean, fixed-width pulses on an external or cross-block line. Each pulse is high for at least `HIGH_W` cycles and low for at least `LOW_W` cycles. A receiving glitch filter of depth n therefore never misses or merges an event when `HIGH_W` and `LOW_W` are at least n+1. Requests that arrive while a pulse is in flight are queued in a saturating pending counter.

---
 rtl/pulse_tx_if.sv | 22 ++
 rtl/pulse_tx.sv | 105 ++++++++++
 2 files changed

// File: rtl/pulse_tx_if.sv
// Request/status bundle for pulse_tx: event requests in, shaped line and queue status out.
interface pulse_tx_if #(
  parameter int CW = 4
) ();
  logic          trig;
  logic          enable;
  logic          clr_ovf;
  logic          d_out;
  logic          busy;
  logic [CW-1:0] pending;
  logic          overflow;

  modport master (
    output trig, enable, clr_ovf,
    input  d_out, busy, pending, overflow
  );

  modport slave (
    input  trig, enable, clr_ovf,
    output d_out, busy, pending, overflow
  );
endinterface

// File: rtl/pulse_tx.sv
// Turns single-cycle event requests into pulses of HIGH_W cycles high and at least
// LOW_W cycles low, queueing requests that arrive mid-pulse in a saturating counter.
module pulse_tx #(
  parameter int HIGH_W = 4,
  parameter int LOW_W  = 4,
  parameter int CW     = 4
) (
  input  logic         clk,
  input  logic         rst,
  pulse_tx_if.slave    bus
);
  localparam int MAXW = (HIGH_W > LOW_W) ? HIGH_W : LOW_W;
  localparam int TW   = (MAXW < 2) ? 1 : $clog2(MAXW + 1);

  typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;

  state_t        state_reg;
  logic [TW-1:0] tmr_reg;
  logic [CW-1:0] pending_reg;
  logic [CW-1:0] pending_next;
  logic          overflow_reg;
  logic          d_out_reg;
  logic          busy_reg;

  logic start_window;
  logic start;
  logic full;
  logic drop;
  logic acc;

  // A new pulse may only begin from IDLE or on the final gap cycle, so the
  // low time between pulses is never shorter than LOW_W.
  always_comb begin
    start_window = (state_reg == IDLE) || ((state_reg == GAP) && (tmr_reg == TW'(1)));
    start        = start_window && bus.enable && ((pending_reg != '0) || bus.trig);
    full         = (pending_reg == {CW{1'b1}});
    drop         = bus.trig && full && !start;
    acc          = bus.trig && !drop;
    pending_next = pending_reg + CW'(acc) - CW'(start);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      tmr_reg      <= '0;
      pending_reg  <= '0;
      overflow_reg <= 1'b0;
      d_out_reg    <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      pending_reg <= pending_next;
      if (drop) begin
        overflow_reg <= 1'b1;
      end else if (bus.clr_ovf) begin
        overflow_reg <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= HIGH;
            tmr_reg   <= TW'(HIGH_W);
            d_out_reg <= 1'b1;
            busy_reg  <= 1'b1;
          end
        end
        HIGH: begin
          if (tmr_reg == TW'(1)) begin
            state_reg <= GAP;
            tmr_reg   <= TW'(LOW_W);
            d_out_reg <= 1'b0;
          end else begin
            tmr_reg <= tmr_reg - TW'(1);
          end
        end
        GAP: begin
          if (tmr_reg == TW'(1)) begin
            if (start) begin
              state_reg <= HIGH;
              tmr_reg   <= TW'(HIGH_W);
              d_out_reg <= 1'b1;
            end else begin
              state_reg <= IDLE;
              tmr_reg   <= '0;
              busy_reg  <= 1'b0;
            end
          end else begin
            tmr_reg <= tmr_reg - TW'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          tmr_reg   <= '0;
          d_out_reg <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.d_out    = d_out_reg;
  assign bus.busy     = busy_reg;
  assign bus.pending  = pending_reg;
  assign bus.overflow = overflow_reg;
endmodule
